mips_pipe_ctrl: RTL and testbench

MIPS_PIPE_CTRL -- requirements
Module: mips_pipe_ctrl

---
 rtl/mips_pipe_pkg.sv | 35 +++
 rtl/mips_fwd_sel.sv | 30 +++
 rtl/mips_pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding control.
// Forward-select encodings, per-stage shadow records and a register-hit helper.
// Register addresses are stored zero-extended to RA_MAX bits inside records.
package mips_pipe_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // Widest register address a record can hold; RA_W must not exceed this.
   localparam int RA_MAX = 8;
   typedef logic [RA_MAX-1:0] ra_t;

   typedef struct packed {
      logic valid;
      logic regwrite;
      logic memread;
      ra_t  wreg;
   } stage_rec_t;

   typedef struct packed {
      stage_rec_t base;
      logic       use_rs;
      logic       use_rt;
      ra_t        rs;
      ra_t        rt;
   } ex_rec_t;

   // True when a used source register is written by a stage; $0 never hits.
   function automatic logic reg_hit(input logic wr, input ra_t wreg,
                                    input logic used, input ra_t src);
      return wr && used && (src != '0) && (wreg == src);
   endfunction

endpackage

// File: rtl/mips_fwd_sel.sv
// Operand source select for one EX operand: MEM result beats WB result beats RF.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of the current stage records.
module mips_fwd_sel
   import mips_pipe_pkg::*;
#(
   parameter int FWD_EN = 1
) (
   input  logic       ex_valid,
   input  logic       use_src,
   input  ra_t        src,
   input  logic       mem_wr,
   input  ra_t        mem_wreg,
   input  logic       wb_wr,
   input  ra_t        wb_wreg,
   output logic [1:0] sel
);

   // Pick the youngest producer of src; nothing is forwarded when disabled.
   always_comb begin
      sel = FWD_RF;
      if ((FWD_EN != 0) && ex_valid) begin
         if (reg_hit(mem_wr, mem_wreg, use_src, src))
            sel = FWD_EXMEM;
         else if (reg_hit(wb_wr, wb_wreg, use_src, src))
            sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Hazard detection, stall/flush control and forwarding selects for a 5-stage MIPS.
// Latency: all control outputs combinational from state and ID inputs (zero cycles).
// Backpressure: stalls hold PC and IF/ID and bubble ID/EX; taken branch overrides stall.
module mips_pipe_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int RA_W   = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [RA_W-1:0]  id_wreg,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             id_jump,
   input  logic             ex_br_taken,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ex_rec_t    ex_q;
   stage_rec_t mem_q;
   stage_rec_t wb_q;

   ra_t  id_rs_x, id_rt_x;
   logic ex_wr, mem_wr, wb_wr;
   logic load_use, raw_any, hazard, stall;
   logic [1:0] sel_a, sel_b;
   logic unused_bits;

   assign id_rs_x = RA_MAX'(id_rs);
   assign id_rt_x = RA_MAX'(id_rt);
   assign ex_wr   = ex_q.base.valid && ex_q.base.regwrite;
   assign mem_wr  = mem_q.valid && mem_q.regwrite;
   assign wb_wr   = wb_q.valid && wb_q.regwrite;
   assign unused_bits = wb_q.memread;

   // Hazard detect: load-use always; without forwarding any in-flight writer stalls.
   always_comb begin
      load_use = reg_hit(ex_wr && ex_q.base.memread, ex_q.base.wreg, id_use_rs, id_rs_x) ||
                 reg_hit(ex_wr && ex_q.base.memread, ex_q.base.wreg, id_use_rt, id_rt_x);
      raw_any  = reg_hit(ex_wr,  ex_q.base.wreg, id_use_rs, id_rs_x) ||
                 reg_hit(ex_wr,  ex_q.base.wreg, id_use_rt, id_rt_x) ||
                 reg_hit(mem_wr, mem_q.wreg,     id_use_rs, id_rs_x) ||
                 reg_hit(mem_wr, mem_q.wreg,     id_use_rt, id_rt_x) ||
                 reg_hit(wb_wr,  wb_q.wreg,      id_use_rs, id_rs_x) ||
                 reg_hit(wb_wr,  wb_q.wreg,      id_use_rt, id_rt_x);
      hazard   = id_valid && (load_use || ((FWD_EN == 0) && raw_any));
   end

   // Control priority: reset, then taken branch, then stall, then jump.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall       = 1'b0;
      if (!rst) begin
         if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (hazard) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            stall       = 1'b1;
         end else if (id_valid && id_jump) begin
            ifid_flush  = 1'b1;
         end
      end
   end

   mips_fwd_sel #(.FWD_EN(FWD_EN)) u_fwd_a (
      .ex_valid (ex_q.base.valid),
      .use_src  (ex_q.use_rs),
      .src      (ex_q.rs),
      .mem_wr   (mem_wr),
      .mem_wreg (mem_q.wreg),
      .wb_wr    (wb_wr),
      .wb_wreg  (wb_q.wreg),
      .sel      (sel_a)
   );

   mips_fwd_sel #(.FWD_EN(FWD_EN)) u_fwd_b (
      .ex_valid (ex_q.base.valid),
      .use_src  (ex_q.use_rt),
      .src      (ex_q.rt),
      .mem_wr   (mem_wr),
      .mem_wreg (mem_q.wreg),
      .wb_wr    (wb_wr),
      .wb_wreg  (wb_q.wreg),
      .sel      (sel_b)
   );

   assign fwd_a = rst ? FWD_RF : sel_a;
   assign fwd_b = rst ? FWD_RF : sel_b;

   // Advance shadow records one stage per clock; a bubble enters EX as invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q.base.valid    <= id_valid && !idex_bubble;
         ex_q.base.regwrite <= id_regwrite;
         ex_q.base.memread  <= id_memread;
         ex_q.base.wreg     <= RA_MAX'(id_wreg);
         ex_q.use_rs        <= id_use_rs;
         ex_q.use_rt        <= id_use_rt;
         ex_q.rs            <= id_rs_x;
         ex_q.rt            <= id_rt_x;
         mem_q              <= ex_q.base;
         wb_q               <= mem_q;
      end
   end

   // Saturating event counters for stall cycles and IF/ID flush cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (ifid_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Bench for mips_pipe_ctrl: one forwarding instance and one stall-only instance.
// Expected control outputs are queued as each ID slot is driven and checked mid-cycle.
// Counter expectations come from a small saturating model fed by the expected stalls/flushes.
module tb_mips_pipe_ctrl;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic [4:0] wreg;
      logic       regwrite;
      logic       memread;
      logic       jump;
      logic       br;
   } in_t;

   typedef struct packed {
      logic       stall;
      logic       fl;
      logic       bub;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   typedef struct {
      int   d;
      logic r;
      exp_t e;
   } sb_item_t;

   logic clk = 1'b0;
   logic rst;
   in_t  in_f, in_n;

   logic       pc_we_f, ifid_we_f, fl_f, bub_f;
   logic [1:0] fa_f, fb_f;
   logic [3:0] sc_f, fc_f;
   logic       pc_we_n, ifid_we_n, fl_n, bub_n;
   logic [1:0] fa_n, fb_n;
   logic [3:0] sc_n, fc_n;

   sb_item_t sb[$];
   int errs   = 0;
   int checks = 0;
   int ncyc   = 0;
   int m_stall[2];
   int m_flush[2];

   always #5 clk = ~clk;

   mips_pipe_ctrl #(.RA_W(5), .FWD_EN(1), .CNT_W(4)) dut_f (
      .clk(clk), .rst(rst), .id_valid(in_f.valid), .id_rs(in_f.rs), .id_rt(in_f.rt),
      .id_use_rs(in_f.use_rs), .id_use_rt(in_f.use_rt), .id_wreg(in_f.wreg),
      .id_regwrite(in_f.regwrite), .id_memread(in_f.memread), .id_jump(in_f.jump),
      .ex_br_taken(in_f.br), .pc_we(pc_we_f), .ifid_we(ifid_we_f), .ifid_flush(fl_f),
      .idex_bubble(bub_f), .fwd_a(fa_f), .fwd_b(fb_f), .stall_cnt(sc_f), .flush_cnt(fc_f)
   );

   mips_pipe_ctrl #(.RA_W(5), .FWD_EN(0), .CNT_W(4)) dut_n (
      .clk(clk), .rst(rst), .id_valid(in_n.valid), .id_rs(in_n.rs), .id_rt(in_n.rt),
      .id_use_rs(in_n.use_rs), .id_use_rt(in_n.use_rt), .id_wreg(in_n.wreg),
      .id_regwrite(in_n.regwrite), .id_memread(in_n.memread), .id_jump(in_n.jump),
      .ex_br_taken(in_n.br), .pc_we(pc_we_n), .ifid_we(ifid_we_n), .ifid_flush(fl_n),
      .idex_bubble(bub_n), .fwd_a(fa_n), .fwd_b(fb_n), .stall_cnt(sc_n), .flush_cnt(fc_n)
   );

   function automatic in_t i_nop();
      in_t i = '0;
      return i;
   endfunction

   function automatic in_t i_alu(input int d, input int s, input int t);
      in_t i = '0;
      i.valid = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.use_rs = 1'b1; i.use_rt = 1'b1;
      i.wreg = 5'(d); i.regwrite = 1'b1;
      return i;
   endfunction

   function automatic in_t i_lw(input int d, input int s);
      in_t i = '0;
      i.valid = 1'b1; i.rs = 5'(s); i.use_rs = 1'b1;
      i.wreg = 5'(d); i.regwrite = 1'b1; i.memread = 1'b1;
      return i;
   endfunction

   function automatic in_t i_jr(input int s, input logic use_s);
      in_t i = '0;
      i.valid = 1'b1; i.rs = 5'(s); i.use_rs = use_s; i.jump = 1'b1;
      return i;
   endfunction

   function automatic in_t with_br(input in_t i);
      in_t o = i;
      o.br = 1'b1;
      return o;
   endfunction

   function automatic exp_t mk(input logic stall, input logic fl, input logic bub,
                               input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      e.stall = stall; e.fl = fl; e.bub = bub; e.fa = fa; e.fb = fb;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one ID slot into DUT d, queue its expectation, compare at the falling edge.
   task automatic cyc(input int d, input in_t i, input logic r, input exp_t e);
      sb_item_t it;
      string    p;
      rst  = r;
      in_f = (d == 0) ? i : i_nop();
      in_n = (d == 1) ? i : i_nop();
      sb.push_back('{d: d, r: r, e: e});
      @(negedge clk);
      it = sb.pop_front();
      p  = $sformatf("%s.c%0d", (it.d == 0) ? "fwd" : "nofwd", ncyc);
      if (it.d == 0) begin
         chk({p, ".pc_we"},   32'(pc_we_f),   32'(!it.e.stall));
         chk({p, ".ifid_we"}, 32'(ifid_we_f), 32'(!it.e.stall));
         chk({p, ".flush"},   32'(fl_f),      32'(it.e.fl));
         chk({p, ".bubble"},  32'(bub_f),     32'(it.e.bub));
         chk({p, ".fwd_a"},   32'(fa_f),      32'(it.e.fa));
         chk({p, ".fwd_b"},   32'(fb_f),      32'(it.e.fb));
         chk({p, ".stall_cnt"}, 32'(sc_f),    32'(m_stall[0]));
         chk({p, ".flush_cnt"}, 32'(fc_f),    32'(m_flush[0]));
      end else begin
         chk({p, ".pc_we"},   32'(pc_we_n),   32'(!it.e.stall));
         chk({p, ".ifid_we"}, 32'(ifid_we_n), 32'(!it.e.stall));
         chk({p, ".flush"},   32'(fl_n),      32'(it.e.fl));
         chk({p, ".bubble"},  32'(bub_n),     32'(it.e.bub));
         chk({p, ".fwd_a"},   32'(fa_n),      32'(it.e.fa));
         chk({p, ".fwd_b"},   32'(fb_n),      32'(it.e.fb));
         chk({p, ".stall_cnt"}, 32'(sc_n),    32'(m_stall[1]));
         chk({p, ".flush_cnt"}, 32'(fc_n),    32'(m_flush[1]));
      end
      if (it.r) begin
         for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0;
            m_flush[k] = 0;
         end
      end else begin
         if (it.e.stall && m_stall[it.d] < 15) m_stall[it.d]++;
         if (it.e.fl && m_flush[it.d] < 15) m_flush[it.d]++;
      end
      ncyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t idle;
      idle = mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      for (int k = 0; k < 2; k++) begin
         m_stall[k] = 0;
         m_flush[k] = 0;
      end
      rst  = 1'b1;
      in_f = i_nop();
      in_n = i_nop();
      repeat (2) @(posedge clk);
      #1;

      // Reset forces idle outputs even with a taken branch and jump asserted.
      cyc(0, with_br(i_jr(1, 1'b1)), 1'b1, idle);

      // lw $2 ; add $3,$2,$4 : one stall, then WB forward on operand A.
      cyc(0, i_lw(2, 1),      1'b0, idle);
      cyc(0, i_alu(3, 2, 4),  1'b0, mk(1, 0, 1, 2'b00, 2'b00));
      cyc(0, i_alu(3, 2, 4),  1'b0, idle);
      cyc(0, i_nop(),         1'b0, mk(0, 0, 0, 2'b10, 2'b00));

      // add $5 ; sub $6,$5,$5 : no stall, both operands from MEM.
      cyc(0, i_alu(5, 1, 1),  1'b0, idle);
      cyc(0, i_alu(6, 5, 5),  1'b0, idle);
      cyc(0, i_nop(),         1'b0, mk(0, 0, 0, 2'b01, 2'b01));

      // $7 written in MEM and WB : MEM wins; $0 is never forwarded or hazarded.
      cyc(0, i_alu(7, 1, 1),  1'b0, idle);
      cyc(0, i_alu(7, 1, 1),  1'b0, idle);
      cyc(0, i_alu(10, 7, 0), 1'b0, idle);
      cyc(0, i_nop(),         1'b0, mk(0, 0, 0, 2'b01, 2'b00));
      cyc(0, i_alu(0, 1, 1),  1'b0, idle);
      cyc(0, i_alu(11, 0, 0), 1'b0, idle);
      cyc(0, i_nop(),         1'b0, idle);
      cyc(0, i_lw(0, 1),      1'b0, idle);
      cyc(0, i_alu(12, 0, 0), 1'b0, idle);
      cyc(0, i_nop(),         1'b0, idle);

      // Taken branch over a load-use hazard: no stall, double squash.
      cyc(0, i_lw(13, 1),              1'b0, idle);
      cyc(0, with_br(i_alu(14, 13, 13)), 1'b0, mk(0, 1, 1, 2'b00, 2'b00));
      cyc(0, i_nop(),                  1'b0, idle);

      // Jumps: plain, stalled by a load then honoured, squashed by a branch.
      cyc(0, i_jr(0, 1'b0),           1'b0, mk(0, 1, 0, 2'b00, 2'b00));
      cyc(0, i_nop(),                 1'b0, idle);
      cyc(0, i_lw(15, 1),             1'b0, idle);
      cyc(0, i_jr(15, 1'b1),          1'b0, mk(1, 0, 1, 2'b00, 2'b00));
      cyc(0, i_jr(15, 1'b1),          1'b0, mk(0, 1, 0, 2'b00, 2'b00));
      cyc(0, with_br(i_jr(0, 1'b0)),  1'b0, mk(0, 1, 1, 2'b10, 2'b00));
      cyc(0, i_nop(),                 1'b0, idle);
      cyc(0, i_nop(),                 1'b0, idle);

      // Repeated load-use to drive stall_cnt into saturation.
      for (int n = 0; n < 14; n++) begin
         cyc(0, i_lw(2, 1),     1'b0, idle);
         cyc(0, i_alu(3, 2, 2), 1'b0, mk(1, 0, 1, 2'b00, 2'b00));
         cyc(0, i_alu(3, 2, 2), 1'b0, idle);
         cyc(0, i_nop(),        1'b0, mk(0, 0, 0, 2'b10, 2'b10));
      end

      // Reset during a stall with a saturated counter; nothing carries over.
      cyc(0, i_lw(2, 1),     1'b0, idle);
      cyc(0, i_alu(3, 2, 2), 1'b1, idle);
      cyc(0, i_alu(3, 2, 2), 1'b0, idle);
      cyc(0, i_nop(),        1'b0, idle);

      // No forwarding: add $8 ; add $9,$8,$0 stalls while $8 is in EX, MEM, WB.
      cyc(1, i_alu(8, 1, 1), 1'b0, idle);
      cyc(1, i_alu(9, 8, 0), 1'b0, mk(1, 0, 1, 2'b00, 2'b00));
      cyc(1, i_alu(9, 8, 0), 1'b0, mk(1, 0, 1, 2'b00, 2'b00));
      cyc(1, i_alu(9, 8, 0), 1'b0, mk(1, 0, 1, 2'b00, 2'b00));
      cyc(1, i_alu(9, 8, 0), 1'b0, idle);
      cyc(1, i_nop(),        1'b0, idle);
      cyc(1, i_nop(),        1'b0, idle);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
